// File: rtl/conv3x3_mac_pipe.sv
// Pipelined 3x3 convolution MAC: products, row sums, then round/ReLU/saturate.
// Three register stages with a global stall driven by output backpressure.
module conv3x3_mac_pipe #(
  parameter int DW    = 8,
  parameter int CW    = 8,
  parameter int OUT_W = 20,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_last,
  input  logic [9*CW-1:0]      filter,
  input  logic [3*DW-1:0]      line1,
  input  logic [3*DW-1:0]      line2,
  input  logic [3*DW-1:0]      line3,
  input  logic                 signed_mode,
  input  logic                 relu_en,
  input  logic [3:0]           shamt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     result,
  output logic                 out_last,
  output logic [CNT_W-1:0]     out_cnt
);
  localparam int PW = DW + CW;
  localparam int SW = PW + 4;
  // Working width covers the rounding carry and the widest saturation limit.
  localparam int XW = (SW + 2 > OUT_W + 2) ? SW + 2 : OUT_W + 2;

  localparam logic signed [XW-1:0] UMAX = {{(XW-OUT_W){1'b0}}, {OUT_W{1'b1}}};
  localparam logic signed [XW-1:0] SMAX = {{(XW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [XW-1:0] SMIN = {{(XW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic advance;
  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance;

  logic [DW-1:0]   pix [9];
  logic [PW+1:0]   a_x, b_x, p_x;
  logic [PW-1:0]   prod_c [9];

  always_comb begin
    for (int c = 0; c < 3; c++) begin
      pix[c]   = line1[c*DW +: DW];
      pix[3+c] = line2[c*DW +: DW];
      pix[6+c] = line3[c*DW +: DW];
    end
  end

  // Low PW bits of the extended product are exact in both modes.
  always_comb begin
    a_x = '0;
    b_x = '0;
    p_x = '0;
    for (int k = 0; k < 9; k++) begin
      a_x = signed_mode ? {{(CW+2){pix[k][DW-1]}}, pix[k]} : {{(CW+2){1'b0}}, pix[k]};
      b_x = signed_mode ? {{(DW+2){filter[k*CW+CW-1]}}, filter[k*CW +: CW]}
                        : {{(DW+2){1'b0}}, filter[k*CW +: CW]};
      p_x = a_x * b_x;
      prod_c[k] = p_x[PW-1:0];
    end
  end

  logic            s1_valid, s1_signed, s1_relu, s1_last;
  logic [3:0]      s1_shamt;
  logic [PW-1:0]   s1_prod [9];

  logic [PW+1:0]   pe;
  logic [PW+1:0]   row_c [3];

  always_comb begin
    pe = '0;
    for (int r = 0; r < 3; r++) begin
      row_c[r] = '0;
      for (int c = 0; c < 3; c++) begin
        pe = s1_signed ? {{2{s1_prod[r*3+c][PW-1]}}, s1_prod[r*3+c]} : {2'b00, s1_prod[r*3+c]};
        row_c[r] = row_c[r] + pe;
      end
    end
  end

  logic            s2_valid, s2_signed, s2_relu, s2_last;
  logic [3:0]      s2_shamt;
  logic [PW+1:0]   s2_row [3];

  logic signed [XW-1:0] row_x, t_sum, t_rnd, t_sh, t_relu, t_sat;
  logic [OUT_W-1:0]     res_next;

  always_comb begin
    row_x = '0;
    t_sum = '0;
    for (int r = 0; r < 3; r++) begin
      row_x = s2_signed ? {{(XW-PW-2){s2_row[r][PW+1]}}, s2_row[r]}
                        : {{(XW-PW-2){1'b0}}, s2_row[r]};
      t_sum = t_sum + row_x;
    end
    t_rnd = '0;
    if (s2_shamt != 4'd0) t_rnd[s2_shamt - 4'd1] = 1'b1;
    // Unsigned sums are zero-extended, so the arithmetic shift acts as a logical one.
    t_sh   = (t_sum + t_rnd) >>> s2_shamt;
    t_relu = (s2_signed && s2_relu && t_sh[XW-1]) ? '0 : t_sh;
    if (s2_signed) begin
      if (t_relu > SMAX)      t_sat = SMAX;
      else if (t_relu < SMIN) t_sat = SMIN;
      else                    t_sat = t_relu;
    end else begin
      if (t_relu[XW-1])       t_sat = '0;
      else if (t_relu > UMAX) t_sat = UMAX;
      else                    t_sat = t_relu;
    end
    res_next = t_sat[OUT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_signed <= 1'b0;
      s1_relu   <= 1'b0;
      s1_last   <= 1'b0;
      s1_shamt  <= '0;
      for (int k = 0; k < 9; k++) s1_prod[k] <= '0;
      s2_valid  <= 1'b0;
      s2_signed <= 1'b0;
      s2_relu   <= 1'b0;
      s2_last   <= 1'b0;
      s2_shamt  <= '0;
      for (int r = 0; r < 3; r++) s2_row[r] <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      out_last  <= 1'b0;
    end else if (advance) begin
      s1_valid  <= in_valid;
      s1_signed <= signed_mode;
      s1_relu   <= relu_en;
      s1_last   <= in_last;
      s1_shamt  <= shamt;
      s1_prod   <= prod_c;
      s2_valid  <= s1_valid;
      s2_signed <= s1_signed;
      s2_relu   <= s1_relu;
      s2_last   <= s1_last;
      s2_shamt  <= s1_shamt;
      s2_row    <= row_c;
      out_valid <= s2_valid;
      if (s2_valid) begin
        result   <= res_next;
        out_last <= s2_last;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        out_cnt <= '0;
    else if (out_valid && out_ready) out_cnt <= out_last ? '0 : out_cnt + 1'b1;
  end

endmodule

// File: tb/tb_conv3x3_mac_pipe.sv
// Directed bench for conv3x3_mac_pipe: default instance plus an OUT_W=16 instance
// sharing the same stimulus to exercise saturation.
module tb_conv3x3_mac_pipe;
  logic        clk, rst, in_valid, in_last, signed_mode, relu_en, out_ready;
  logic [71:0] filter;
  logic [23:0] line1, line2, line3;
  logic [3:0]  shamt;
  logic        in_ready, out_valid, out_last;
  logic [19:0] result;
  logic [15:0] out_cnt;
  logic        in_ready16, out_valid16, out_last16;
  logic [15:0] result16;
  logic [15:0] out_cnt16;

  int n_assert = 0;
  int n_fail   = 0;
  int sent, got, cyc, stall_seen;

  conv3x3_mac_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .filter(filter), .line1(line1), .line2(line2), .line3(line3),
    .signed_mode(signed_mode), .relu_en(relu_en), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .out_last(out_last), .out_cnt(out_cnt)
  );

  conv3x3_mac_pipe #(.OUT_W(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16), .in_last(in_last),
    .filter(filter), .line1(line1), .line2(line2), .line3(line3),
    .signed_mode(signed_mode), .relu_en(relu_en), .shamt(shamt),
    .out_valid(out_valid16), .out_ready(out_ready), .result(result16),
    .out_last(out_last16), .out_cnt(out_cnt16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [71:0] f, input logic [23:0] a, input logic [23:0] b,
                       input logic [23:0] c, input logic sm, input logic re,
                       input logic [3:0] sh, input logic lst);
    filter = f; line1 = a; line2 = b; line3 = c;
    signed_mode = sm; relu_en = re; shamt = sh; in_last = lst;
    in_valid = 1'b1;
  endtask

  // Accept one beat, then land two cycles later where out_valid must be high.
  task automatic run_beat(input logic [71:0] f, input logic [23:0] a, input logic [23:0] b,
                          input logic [23:0] c, input logic sm, input logic re,
                          input logic [3:0] sh, input logic lst);
    drive(f, a, b, c, sm, re, sh, lst);
    tick;
    in_valid = 1'b0;
    tick;
    chk("latency_early", out_valid, 1'b0);
    tick;
    chk("latency_valid", out_valid, 1'b1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; signed_mode = 1'b0; relu_en = 1'b0;
    out_ready = 1'b1; filter = '0; line1 = '0; line2 = '0; line3 = '0; shamt = '0;
    #3;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", result, 20'd0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_out_cnt", out_cnt, 16'd0);
    chk("rst_in_ready", in_ready, 1'b1);
    tick;
    rst = 1'b0;
    tick;

    // unsigned all-255 window: 9*65025
    run_beat({72{1'b1}}, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b0, 4'd0, 1'b0);
    chk("u255_result", result, 20'h8EE09);
    chk("u255_sat16", result16, 16'hFFFF);
    chk("u255_last", out_last, 1'b0);
    chk("u255_cnt_before", out_cnt, 16'd0);
    tick;
    chk("u255_pulse", out_valid, 1'b0);
    chk("u255_hold", result, 20'h8EE09);
    chk("u255_cnt_after", out_cnt, 16'd1);

    run_beat({72{1'b1}}, 24'h020202, 24'h020202, 24'h020202, 1'b1, 1'b0, 4'd0, 1'b0);
    chk("sneg_result", result, 20'hFFFEE);
    chk("sneg_result16", result16, 16'hFFEE);
    tick;

    run_beat({72{1'b1}}, 24'h020202, 24'h020202, 24'h020202, 1'b1, 1'b1, 4'd0, 1'b0);
    chk("relu_result", result, 20'd0);
    chk("relu_result16", result16, 16'd0);
    tick;

    run_beat(72'd5, 24'h000002, 24'd0, 24'd0, 1'b0, 1'b0, 4'd2, 1'b0);
    chk("round_10_sh2", result, 20'd3);
    tick;

    run_beat(72'd9, 24'h000001, 24'd0, 24'd0, 1'b0, 1'b0, 4'd2, 1'b0);
    chk("round_9_sh2", result, 20'd2);
    tick;

    // signed -128 pixels x 127 coeffs: sum -146304
    run_beat({9{8'h7F}}, 24'h808080, 24'h808080, 24'h808080, 1'b1, 1'b0, 4'd0, 1'b0);
    chk("sneg_big", result, 20'hDC480);
    chk("sneg_sat16", result16, 16'h8000);
    tick;

    // -18 rounded and shifted arithmetically by 2: -4
    run_beat({72{1'b1}}, 24'h020202, 24'h020202, 24'h020202, 1'b1, 1'b0, 4'd2, 1'b0);
    chk("sshift_result", result, 20'hFFFFC);
    chk("sshift_result16", result16, 16'hFFFC);
    tick;

    run_beat({72{1'b1}}, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b0, 4'd4, 1'b1);
    chk("ushift_result", result, 20'h08EE1);
    chk("ushift_last", out_last, 1'b1);
    chk("cnt_before_last", out_cnt, 16'd7);
    tick;
    chk("cnt_after_last", out_cnt, 16'd0);
    chk("last_hold", out_last, 1'b1);
    chk("idle_valid", out_valid, 1'b0);
    tick;

    // six back-to-back beats with four cycles of backpressure
    sent = 0; got = 0; cyc = 0; stall_seen = 0;
    while (got < 6 && cyc < 60) begin
      if (sent < 6) drive(72'd1, 24'((sent + 1) * 10), 24'd0, 24'd0, 1'b0, 1'b0, 4'd0, sent == 5);
      else in_valid = 1'b0;
      out_ready = !(cyc >= 5 && cyc < 9);
      #1;
      if (out_valid && !out_ready) begin
        stall_seen++;
        chk("bp_in_ready", in_ready, 1'b0);
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        got++;
        chk("bp_result", result, 64'(got * 10));
        chk("bp_last", out_last, got == 6);
        chk("bp_cnt", out_cnt, 64'(got - 1));
      end
      tick;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_got", got, 6);
    chk("bp_stall_cycles", stall_seen, 4);
    chk("bp_cnt_end", out_cnt, 16'd0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_no_dup", out_valid, 1'b0);
      tick;
    end

    // reset with three beats in flight
    for (int k = 0; k < 4; k++) begin
      drive(72'd1, 24'((k + 1) * 10), 24'd0, 24'd0, 1'b0, 1'b0, 4'd0, 1'b0);
      tick;
    end
    in_valid = 1'b0;
    chk("pre_rst_cnt", out_cnt, 16'd1);
    chk("pre_rst_valid", out_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_cnt", out_cnt, 16'd0);
    chk("mid_rst_result", result, 20'd0);
    tick;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("post_rst_no_stale", out_valid, 1'b0);
      tick;
    end
    run_beat({8'd3, 64'd0}, 24'd0, 24'd0, 24'h070000, 1'b0, 1'b0, 4'd0, 1'b0);
    chk("post_rst_result", result, 20'd21);
    chk("post_rst_cnt", out_cnt, 16'd0);
    tick;
    chk("post_rst_cnt_after", out_cnt, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/conv3x3_mac_pipe.md
Name: conv3x3_mac_pipe

Overview:
Parametrised, pipelined 3x3 convolution MAC: the successor to the single-stage unsigned 8-bit convolution ALU. Each accepted beat carries one 3x3 window (three lines of three pixels) and a 3x3 coefficient set. The block computes a 9-term dot product through a 3-stage pipeline, then applies rounding shift, optional ReLU and saturation. Full ready/valid handshake on both sides, with backpressure and frame-last tracking. Sits between the line-buffer/window generator and the result write-back path.

Parameters:
DW, 8, pixel width
CW, 8, coefficient width
OUT_W, 20, result width
CNT_W, 16, output beat counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  input beat valid
in_ready  out  1  block can accept beat
in_last  in  1  beat is last of frame
filter  in  9*CW  coeff k=r*3+c at [k*CW +: CW]
line1  in  3*DW  row 0, pixel c at [c*DW +: DW]
line2  in  3*DW  row 1
line3  in  3*DW  row 2
signed_mode  in  1  1: pixels and coeffs two's complement; 0: unsigned
relu_en  in  1  clamp negative sums to 0 (signed mode only)
shamt  in  4  right-shift amount applied to the sum
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
result  out  OUT_W  convolution result (signed or unsigned per beat mode)
out_last  out  1  in_last carried with the beat
out_cnt  out  CNT_W  results delivered in the current frame

Behaviour:
- Reset: out_valid=0, result=0, out_last=0, out_cnt=0, all stage valids=0. in_ready=1 after reset. Reset mid-stream discards every in-flight beat; no result is emitted for those beats.
- Handshake: input accepted on an edge where in_valid && in_ready. Output transferred on an edge where out_valid && out_ready.
- Stall = out_valid && !out_ready. in_ready = !stall, combinational. While stalled, all stages hold their data and valids. Bubbles are not compressed.
- signed_mode, relu_en, shamt and in_last are sampled with each accepted beat and travel down the pipeline with it. Mode changes between beats are legal.
- Widths: PW=DW+CW, SW=PW+4. Operands are sign- or zero-extended per signed_mode.
- Stage 1: register the 9 products P[r][c] = coef[r*3+c] * line_{r+1}[c], each PW bits.
- Stage 2: register the three row sums, each PW+2 bits.
- Stage 3 (output register):
  - T = sum of the rows, SW bits.
  - If shamt>0: T = (T + 2^(shamt-1)) >>> shamt. The shift is arithmetic in signed mode and logical otherwise; this rounds half up.
  - If signed_mode && relu_en && T<0: T = 0.
  - Saturate to OUT_W. Unsigned: clamp to [0, 2^OUT_W-1]. Signed: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Latency: 3 cycles. A beat accepted at edge N has out_valid=1 after edge N+2. Throughput is 1 beat/cycle when out_ready=1.
- When no beat is valid at stage 3, result and out_last keep their last value and out_valid=0.
- out_cnt:
  - Increments on each output transfer.
  - On a transfer with out_last=1, it returns to 0 on that edge.
  - Wraps modulo 2^CNT_W.
  - Reflects the registered count, i.e. the transfers already completed.
- Simultaneous events: an input accept and an output transfer on the same edge are both honoured. When out_ready rises, the stall releases and the pipeline advances on that same edge.

Test Plan:
- Unsigned, all pixels and coeffs 255, shamt=0, out_ready=1 → result=585225 three cycles after accept; out_valid is a single 1-cycle pulse.
- Signed, coeffs all 0xFF (-1), pixels all 2 → result=-18 (0xFFFEE); repeat with relu_en=1 → result=0.
- Unsigned, single nonzero term 10 (coef 5, pixel 2), shamt=2 → result=3. With sum 9, shamt=2 → result=2 (9+2=11, >>2).
- Saturation:
  - OUT_W=16 instance, unsigned all 255 → result=65535.
  - OUT_W=16 instance, signed pixels -128 and coeffs 127 → sum=-146304, result=-32768.
- Backpressure: stream 6 back-to-back beats with in_last on beat 6; hold out_ready=0 for 4 cycles mid-stream.
  - in_ready=0 throughout the stall.
  - All 6 results arrive in order with none lost or duplicated.
  - out_last is set only on result 6; out_cnt goes 1..5, then 0 after the 6th transfer.
- Assert rst for 1 cycle while 3 beats are in flight → out_valid=0, out_cnt=0 immediately; no stale result emitted afterwards; the next beat produces a correct result after 3 cycles.
